pulse_shrink: RTL and testbench
===============================

PULSE_SHRINK -- requirements
Module: pulse_shrink

Interface
REQ-001 The block SHALL have parameter STRETCH, default 3, meaning the number of cycles the upstream stretcher appends to each pulse.
REQ-002 The block SHALL have parameter MAX_W, default 15, meaning the longest legal stretched high time in cycles.
REQ-003 The block SHALL have parameter CNT_W, default 4, meaning the counter and width-port width; CNT_W SHALL hold MAX_W.
REQ-004 The block SHALL have port clk, input, 1 bit: single clock; all logic on its rising edge.
REQ-005 The block SHALL have port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-006 The block SHALL have port d, input, 1 bit: stretched pulse, synchronous to clk.
REQ-007 The block SHALL have port q, output, 1 bit: single-cycle strobe marking one accepted pulse.
REQ-008 The block SHALL have port orig_w, output, CNT_W bits: recovered original width (measured high time minus STRETCH), valid with q.
REQ-009 The block SHALL have port err_short, output, 1 bit: single-cycle flag for a pulse of STRETCH cycles or fewer.
REQ-010 The block SHALL have port err_long, output, 1 bit: single-cycle flag for a pulse exceeding MAX_W.
REQ-011 The block SHALL have port busy, output, 1 bit: high while a pulse is being measured.

Function
REQ-012 The block SHALL use FSM states IDLE, HIGH and LONG.
REQ-013 In IDLE with d=1, the block SHALL go to HIGH with cnt=1.
REQ-014 In IDLE with d=0, the block SHALL stay in IDLE.
REQ-015 In HIGH with d=1 and cnt<MAX_W, the block SHALL increment cnt.
REQ-016 In HIGH with d=1 and cnt==MAX_W, the block SHALL go to LONG and pulse err_long for exactly one cycle.
REQ-017 In HIGH with d=0 and cnt>STRETCH, the block SHALL go to IDLE, pulse q for one cycle, and drive orig_w=cnt-STRETCH in the same cycle.
REQ-018 In HIGH with d=0 and cnt<=STRETCH, the block SHALL go to IDLE and pulse err_short for one cycle; q SHALL stay 0.
REQ-019 In LONG, the block SHALL ignore d=1 and go to IDLE on d=0, with no q and no further err_long.
REQ-020 Latency SHALL be fixed: q, err_short and err_long SHALL be registered and assert in the cycle after the edge that samples the triggering d value.
REQ-021 orig_w SHALL hold its last value when q=0.
REQ-022 busy SHALL equal (state != IDLE).
REQ-023 Back-to-back pulses separated by one low cycle SHALL each be measured; a d=1 sampled in the cycle q asserts SHALL start a new count at cnt=1.
REQ-024 At most one of q, err_short and err_long SHALL be high in any cycle.
REQ-025 cnt SHALL never wrap; it saturates at MAX_W via the LONG transition.

Reset
REQ-026 Asserting rst_n=0 SHALL immediately force state=IDLE, cnt=0, q=0, orig_w=0, err_short=0, err_long=0 and busy=0, independent of clk.
REQ-027 Reset asserted mid-pulse SHALL discard the measurement with no q or error flag.
REQ-028 After reset deassertion, a d already high SHALL be treated as a new pulse starting at the first sampling edge.
REQ-029 Reset deassertion is synchronized externally; the block SHALL require no internal deassertion logic.

Structure
REQ-030 The shared package pulse_shrink_pkg SHALL hold the state enum (IDLE, HIGH, LONG) and the default STRETCH and MAX_W constants.
REQ-031 The block SHALL use exactly one sub-module, pulse_width_cnt: a saturating counter with clear, enable and at-max outputs.
REQ-032 The FSM and output registers SHALL live in pulse_shrink.

Verification
REQ-033 Scenario: d high 4 cycles -> one q pulse 1 cycle after the falling sample, orig_w=1, no error flags.
REQ-034 Scenario: d high 10 cycles -> q with orig_w=7.
REQ-035 Scenario: d high 3 cycles -> err_short one cycle; q stays 0.
REQ-036 Scenario: d high 20 cycles -> err_long one cycle at cnt=15, busy high until d falls, no q.
REQ-037 Scenario: pulses of 5 high, 1 low, 6 high -> two q pulses with orig_w=2, then 3.
REQ-038 Scenario: rst_n low at cycle 3 of an 8-cycle pulse, released while d is high -> no q for the aborted pulse; the remainder is measured from cnt=1.

Source files
------------

// File: rtl/pulse_shrink_pkg.sv
// pulse_shrink_pkg
//   Shared definitions for the pulse shrinker: the measurement FSM state
//   encoding and the default stretch / maximum-width / counter-width values.
package pulse_shrink_pkg;

    localparam int DEF_STRETCH = 3;   // cycles appended by the upstream stretcher
    localparam int DEF_MAX_W   = 15;  // longest legal stretched high time
    localparam int DEF_CNT_W   = 4;   // must be wide enough to hold DEF_MAX_W

    typedef enum logic [1:0] {
        IDLE = 2'd0,  // waiting for d to rise
        HIGH = 2'd1,  // measuring a pulse
        LONG = 2'd2   // pulse overran MAX_W, waiting for d to fall
    } state_t;

endpackage

// File: rtl/pulse_width_cnt.sv
// pulse_width_cnt
//   Saturating high-time counter.
//   Ports:
//     clk, rst_n : clock, asynchronous active-low reset
//     clr        : restart the count (to 1 if en is also high, else to 0)
//     en         : count one more high cycle; holds once MAX_W is reached
//     cnt        : current count
//     at_max     : cnt == MAX_W
module pulse_width_cnt #(
    parameter int MAX_W = 15,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             en,
    output logic [CNT_W-1:0] cnt,
    output logic             at_max
);

    assign at_max = (cnt == CNT_W'(MAX_W));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            // clr together with en means "the first high cycle of a new pulse"
            cnt <= en ? CNT_W'(1) : '0;
        end else if (en && !at_max) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/pulse_shrink.sv
// pulse_shrink
//   Measures the high time of a stretched pulse on d and recovers the
//   original width by removing the STRETCH cycles added upstream.
//   Ports:
//     clk, rst_n : clock, asynchronous active-low reset
//     d          : stretched pulse input, synchronous to clk
//     q          : one-cycle strobe per accepted pulse
//     orig_w     : recovered width (high time - STRETCH), valid with q, held otherwise
//     err_short  : one-cycle flag, pulse was STRETCH cycles or fewer
//     err_long   : one-cycle flag, pulse exceeded MAX_W cycles
//     busy       : high while a pulse is being measured (state != IDLE)
//     state_dbg  : current FSM state, for observation only
//   Output handshake: q/err_short/err_long are mutually exclusive single-cycle
//   strobes with no back-pressure; orig_w is qualified by q.
module pulse_shrink
    import pulse_shrink_pkg::*;
#(
    parameter int STRETCH = DEF_STRETCH,
    parameter int MAX_W   = DEF_MAX_W,
    parameter int CNT_W   = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             d,
    output logic             q,
    output logic [CNT_W-1:0] orig_w,
    output logic             err_short,
    output logic             err_long,
    output logic             busy,
    output state_t           state_dbg
);

    localparam logic [CNT_W-1:0] STRETCH_C = CNT_W'(STRETCH);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             at_max;
    logic             cnt_clr;
    logic             cnt_en;

    // Counter control follows the state the FSM is leaving: a rising d in
    // IDLE restarts at 1, d high in HIGH keeps counting, anything else clears.
    always_comb begin
        cnt_clr = 1'b1;
        cnt_en  = 1'b0;
        case (state)
            IDLE: begin
                cnt_clr = 1'b1;
                cnt_en  = d;
            end
            HIGH: begin
                cnt_clr = !d;
                cnt_en  = d;
            end
            default: begin
                cnt_clr = 1'b1;
                cnt_en  = 1'b0;
            end
        endcase
    end

    pulse_width_cnt #(
        .MAX_W (MAX_W),
        .CNT_W (CNT_W)
    ) u_cnt (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr    (cnt_clr),
        .en     (cnt_en),
        .cnt    (cnt),
        .at_max (at_max)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            q         <= 1'b0;
            orig_w    <= '0;
            err_short <= 1'b0;
            err_long  <= 1'b0;
        end else begin
            q         <= 1'b0;
            err_short <= 1'b0;
            err_long  <= 1'b0;
            case (state)
                IDLE: begin
                    if (d) begin
                        state <= HIGH;
                    end
                end
                HIGH: begin
                    if (d) begin
                        // One more high cycle with cnt already at MAX_W means overrun
                        if (at_max) begin
                            state    <= LONG;
                            err_long <= 1'b1;
                        end
                    end else begin
                        state <= IDLE;
                        if (cnt > STRETCH_C) begin
                            q      <= 1'b1;
                            orig_w <= cnt - STRETCH_C;
                        end else begin
                            err_short <= 1'b1;
                        end
                    end
                end
                LONG: begin
                    // Overrun pulse is dropped silently until d falls
                    if (!d) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign busy      = (state != IDLE);
    assign state_dbg = state;

endmodule

// File: tb/tb_pulse_shrink.sv
// tb_pulse_shrink
//   Directed pulses with hand-computed results; a scoreboard queue holds the
//   expected event (kind, width) and the cycle it must appear in, and a
//   monitor on the falling clock edge pops and compares each DUT event.
module tb_pulse_shrink;
    import pulse_shrink_pkg::*;

    localparam int MAX_W = 15;
    localparam int CNT_W = 4;

    localparam logic [1:0] K_Q     = 2'd1;
    localparam logic [1:0] K_SHORT = 2'd2;
    localparam logic [1:0] K_LONG  = 2'd3;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             d;
    logic             q;
    logic [CNT_W-1:0] orig_w;
    logic             err_short;
    logic             err_long;
    logic             busy;
    state_t           state_dbg;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    logic [5:0]       exp_q[$];      // {kind, width}
    int               exp_cyc_q[$];  // cycle the event must appear in
    logic [CNT_W-1:0] last_w;

    pulse_shrink dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .d         (d),
        .q         (q),
        .orig_w    (orig_w),
        .err_short (err_short),
        .err_long  (err_long),
        .busy      (busy),
        .state_dbg (state_dbg)
    );

    // ---------------- clock / cycle counter ----------------
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- compare helper ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- monitor / scoreboard ----------------
    always @(negedge clk) begin
        logic [1:0] k;
        logic [5:0] e;
        int         ec;
        if (!rst_n) begin
            check("rst_flags", 32'({q, err_short, err_long}), 32'd0);
            check("rst_orig_w", 32'(orig_w), 32'd0);
            last_w = '0;
        end else if (q || err_short || err_long) begin
            check("onehot", 32'($countones({q, err_short, err_long})), 32'd1);
            k = q ? K_Q : (err_short ? K_SHORT : K_LONG);
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_event: got kind %0d at cycle %0d expected none", k, cyc);
            end else begin
                e  = exp_q.pop_front();
                ec = exp_cyc_q.pop_front();
                check("kind", 32'(k), 32'(e[5:4]));
                check("latency", 32'(cyc), 32'(ec));
                if (q) begin
                    check("orig_w", 32'(orig_w), 32'(e[3:0]));
                    last_w = e[3:0];
                end
            end
        end else begin
            check("orig_w_hold", 32'(orig_w), 32'(last_w));
        end
    end

    // ---------------- driver tasks (called at a falling edge) ----------------
    task automatic pulse(input int h, input int l, input logic [1:0] k, input logic [3:0] w);
        int c;
        c = cyc;
        d = 1'b1;
        exp_q.push_back({k, w});
        // Long pulses report after the (MAX_W+1)-th high sample, others one
        // cycle after the first low sample.
        exp_cyc_q.push_back((k == K_LONG) ? c + 1 + MAX_W : c + 1 + h);
        repeat (h) @(negedge clk);
        check("busy_high", 32'(busy), 32'd1);
        d = 1'b0;
        if (l > 0) begin
            @(negedge clk);
            check("busy_low", 32'(busy), 32'd0);
            repeat (l - 1) @(negedge clk);
        end
    endtask

    // 8-cycle pulse with reset pulsed after its third high sample; only the
    // four high samples after release form the measured pulse (4 - 3 = 1).
    task automatic reset_mid_pulse();
        int c;
        c = cyc;
        d = 1'b1;
        exp_q.push_back({K_Q, 4'd1});
        exp_cyc_q.push_back(c + 9);
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_orig_w", 32'(orig_w), 32'd0);
        check("mid_rst_state", 32'(state_dbg), 32'(IDLE));
        @(negedge clk);
        #2 rst_n = 1'b1;
        repeat (4) @(negedge clk);
        d = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        rst_n = 1'b0;
        d     = 1'b0;
        #1;
        check("init_q", 32'(q), 32'd0);
        check("init_err", 32'({err_short, err_long}), 32'd0);
        check("init_orig_w", 32'(orig_w), 32'd0);
        check("init_busy", 32'(busy), 32'd0);
        check("init_state", 32'(state_dbg), 32'(IDLE));
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);

        pulse(4,  3, K_Q,     4'd1);   // shortest accepted pulse
        pulse(10, 3, K_Q,     4'd7);
        pulse(3,  3, K_SHORT, 4'd0);   // exactly STRETCH cycles
        pulse(20, 3, K_LONG,  4'd0);
        pulse(5,  1, K_Q,     4'd2);   // back-to-back, one low cycle
        pulse(6,  3, K_Q,     4'd3);
        pulse(1,  2, K_SHORT, 4'd0);
        pulse(15, 3, K_Q,     4'd12);  // longest legal pulse
        pulse(16, 3, K_LONG,  4'd0);   // one past the limit
        reset_mid_pulse();
        pulse(7,  3, K_Q,     4'd4);

        for (int i = 0; i < 50 && exp_q.size() != 0; i++) @(negedge clk);
        check("drain", 32'(exp_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
